// File: rtl/tcp_rx_ptr_store.sv
// Per-flow RX head/commit pointer store for the TCP RX path.
// Clears both tables after reset, then serves init, engine and app accesses.
module tcp_rx_ptr_store #(
   parameter int unsigned FLOWID_W = 6,
   parameter int unsigned PTR_W    = 32
) (
   input  logic                clk,
   input  logic                rst,

   input  logic                init_req_val,
   input  logic [FLOWID_W-1:0] init_req_flowid,
   input  logic [PTR_W-1:0]    init_req_ptr,
   output logic                init_req_rdy,

   input  logic                eng_commit_wr_req_val,
   input  logic [FLOWID_W-1:0] eng_commit_wr_req_flowid,
   input  logic [PTR_W-1:0]    eng_commit_wr_req_ptr,
   output logic                commit_eng_wr_req_rdy,

   input  logic                app_rx_head_ptr_wr_req_val,
   input  logic [FLOWID_W-1:0] app_rx_head_ptr_wr_req_flowid,
   input  logic [PTR_W-1:0]    app_rx_head_ptr_wr_req_ptr,
   output logic                rx_head_ptr_app_wr_req_rdy,

   input  logic                app_rx_head_ptr_rd_req_val,
   input  logic [FLOWID_W-1:0] app_rx_head_ptr_rd_req_flowid,
   output logic                rx_head_ptr_app_rd_req_rdy,
   output logic                rx_head_ptr_app_rd_resp_val,
   output logic [PTR_W-1:0]    rx_head_ptr_app_rd_resp_ptr,
   input  logic                app_rx_head_ptr_rd_resp_rdy,

   input  logic                app_rx_commit_ptr_rd_req_val,
   input  logic [FLOWID_W-1:0] app_rx_commit_ptr_rd_req_flowid,
   output logic                rx_commit_ptr_app_rd_req_rdy,
   output logic                rx_commit_ptr_app_rd_resp_val,
   output logic [PTR_W-1:0]    rx_commit_ptr_app_rd_resp_ptr,
   input  logic                app_rx_commit_ptr_rd_resp_rdy
);

   localparam int unsigned DEPTH = 1 << FLOWID_W;

   typedef enum logic {ST_CLEAR, ST_RUN} state_e;

   state_e              state_q, state_d;
   logic [FLOWID_W-1:0] clr_idx_q, clr_idx_d;

   logic                head_resp_val_q, head_resp_val_d;
   logic [PTR_W-1:0]    head_resp_ptr_q, head_resp_ptr_d;
   logic                commit_resp_val_q, commit_resp_val_d;
   logic [PTR_W-1:0]    commit_resp_ptr_q, commit_resp_ptr_d;

   logic [PTR_W-1:0]    head_mem   [DEPTH];
   logic [PTR_W-1:0]    commit_mem [DEPTH];

   logic                run;
   logic                head_we, commit_we;
   logic [FLOWID_W-1:0] head_wa, commit_wa;
   logic [PTR_W-1:0]    head_wd, commit_wd;
   logic                head_rd_acc, commit_rd_acc;
   logic [PTR_W-1:0]    head_rd_data, commit_rd_data;

   assign run = (state_q == ST_RUN);

   assign init_req_rdy                 = run;
   assign commit_eng_wr_req_rdy        = run & ~init_req_val;
   assign rx_head_ptr_app_wr_req_rdy   = run & ~init_req_val;
   assign rx_head_ptr_app_rd_req_rdy   = run & (~head_resp_val_q | app_rx_head_ptr_rd_resp_rdy);
   assign rx_commit_ptr_app_rd_req_rdy = run & (~commit_resp_val_q | app_rx_commit_ptr_rd_resp_rdy);

   assign rx_head_ptr_app_rd_resp_val   = head_resp_val_q;
   assign rx_head_ptr_app_rd_resp_ptr   = head_resp_ptr_q;
   assign rx_commit_ptr_app_rd_resp_val = commit_resp_val_q;
   assign rx_commit_ptr_app_rd_resp_ptr = commit_resp_ptr_q;

   assign head_rd_acc   = app_rx_head_ptr_rd_req_val & rx_head_ptr_app_rd_req_rdy;
   assign commit_rd_acc = app_rx_commit_ptr_rd_req_val & rx_commit_ptr_app_rd_req_rdy;

   // Write port select: clear sweep, then init over app/engine.
   always_comb begin
      head_we   = 1'b0;
      head_wa   = '0;
      head_wd   = '0;
      commit_we = 1'b0;
      commit_wa = '0;
      commit_wd = '0;
      if (!run) begin
         head_we   = 1'b1;
         head_wa   = clr_idx_q;
         commit_we = 1'b1;
         commit_wa = clr_idx_q;
      end else if (init_req_val) begin
         head_we   = 1'b1;
         head_wa   = init_req_flowid;
         head_wd   = init_req_ptr;
         commit_we = 1'b1;
         commit_wa = init_req_flowid;
         commit_wd = init_req_ptr;
      end else begin
         if (app_rx_head_ptr_wr_req_val) begin
            head_we = 1'b1;
            head_wa = app_rx_head_ptr_wr_req_flowid;
            head_wd = app_rx_head_ptr_wr_req_ptr;
         end
         if (eng_commit_wr_req_val) begin
            commit_we = 1'b1;
            commit_wa = eng_commit_wr_req_flowid;
            commit_wd = eng_commit_wr_req_ptr;
         end
      end
   end

   // Write-first bypass so a same-cycle read of the written flow sees new data.
   always_comb begin
      head_rd_data   = (head_we && head_wa == app_rx_head_ptr_rd_req_flowid)
                       ? head_wd : head_mem[app_rx_head_ptr_rd_req_flowid];
      commit_rd_data = (commit_we && commit_wa == app_rx_commit_ptr_rd_req_flowid)
                       ? commit_wd : commit_mem[app_rx_commit_ptr_rd_req_flowid];
   end

   always_comb begin
      state_d           = state_q;
      clr_idx_d         = clr_idx_q;
      head_resp_val_d   = head_resp_val_q;
      head_resp_ptr_d   = head_resp_ptr_q;
      commit_resp_val_d = commit_resp_val_q;
      commit_resp_ptr_d = commit_resp_ptr_q;

      if (state_q == ST_CLEAR) begin
         clr_idx_d = clr_idx_q + 1'b1;
         if (clr_idx_q == '1) begin
            state_d = ST_RUN;
         end
      end

      if (head_rd_acc) begin
         head_resp_val_d = 1'b1;
         head_resp_ptr_d = head_rd_data;
      end else if (app_rx_head_ptr_rd_resp_rdy) begin
         head_resp_val_d = 1'b0;
      end

      if (commit_rd_acc) begin
         commit_resp_val_d = 1'b1;
         commit_resp_ptr_d = commit_rd_data;
      end else if (app_rx_commit_ptr_rd_resp_rdy) begin
         commit_resp_val_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q           <= ST_CLEAR;
         clr_idx_q         <= '0;
         head_resp_val_q   <= 1'b0;
         head_resp_ptr_q   <= '0;
         commit_resp_val_q <= 1'b0;
         commit_resp_ptr_q <= '0;
      end else begin
         state_q           <= state_d;
         clr_idx_q         <= clr_idx_d;
         head_resp_val_q   <= head_resp_val_d;
         head_resp_ptr_q   <= head_resp_ptr_d;
         commit_resp_val_q <= commit_resp_val_d;
         commit_resp_ptr_q <= commit_resp_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (head_we) begin
         head_mem[head_wa] <= head_wd;
      end
      if (commit_we) begin
         commit_mem[commit_wa] <= commit_wd;
      end
   end

endmodule

// File: tb/tb_tcp_rx_ptr_store.sv
// Directed self-checking bench for tcp_rx_ptr_store.
module tb_tcp_rx_ptr_store;

   localparam int unsigned FLOWID_W = 6;
   localparam int unsigned PTR_W    = 32;

   logic                clk = 1'b0;
   logic                rst;
   logic                init_req_val;
   logic [FLOWID_W-1:0] init_req_flowid;
   logic [PTR_W-1:0]    init_req_ptr;
   logic                init_req_rdy;
   logic                eng_commit_wr_req_val;
   logic [FLOWID_W-1:0] eng_commit_wr_req_flowid;
   logic [PTR_W-1:0]    eng_commit_wr_req_ptr;
   logic                commit_eng_wr_req_rdy;
   logic                app_rx_head_ptr_wr_req_val;
   logic [FLOWID_W-1:0] app_rx_head_ptr_wr_req_flowid;
   logic [PTR_W-1:0]    app_rx_head_ptr_wr_req_ptr;
   logic                rx_head_ptr_app_wr_req_rdy;
   logic                app_rx_head_ptr_rd_req_val;
   logic [FLOWID_W-1:0] app_rx_head_ptr_rd_req_flowid;
   logic                rx_head_ptr_app_rd_req_rdy;
   logic                rx_head_ptr_app_rd_resp_val;
   logic [PTR_W-1:0]    rx_head_ptr_app_rd_resp_ptr;
   logic                app_rx_head_ptr_rd_resp_rdy;
   logic                app_rx_commit_ptr_rd_req_val;
   logic [FLOWID_W-1:0] app_rx_commit_ptr_rd_req_flowid;
   logic                rx_commit_ptr_app_rd_req_rdy;
   logic                rx_commit_ptr_app_rd_resp_val;
   logic [PTR_W-1:0]    rx_commit_ptr_app_rd_resp_ptr;
   logic                app_rx_commit_ptr_rd_resp_rdy;

   logic [4:0] rdy_all;
   int vec = 0;
   int err = 0;

   assign rdy_all = {init_req_rdy, commit_eng_wr_req_rdy, rx_head_ptr_app_wr_req_rdy,
                     rx_head_ptr_app_rd_req_rdy, rx_commit_ptr_app_rd_req_rdy};

   always #5 clk = ~clk;

   tcp_rx_ptr_store #(.FLOWID_W(FLOWID_W), .PTR_W(PTR_W)) dut (
      .clk(clk), .rst(rst),
      .init_req_val(init_req_val), .init_req_flowid(init_req_flowid),
      .init_req_ptr(init_req_ptr), .init_req_rdy(init_req_rdy),
      .eng_commit_wr_req_val(eng_commit_wr_req_val),
      .eng_commit_wr_req_flowid(eng_commit_wr_req_flowid),
      .eng_commit_wr_req_ptr(eng_commit_wr_req_ptr),
      .commit_eng_wr_req_rdy(commit_eng_wr_req_rdy),
      .app_rx_head_ptr_wr_req_val(app_rx_head_ptr_wr_req_val),
      .app_rx_head_ptr_wr_req_flowid(app_rx_head_ptr_wr_req_flowid),
      .app_rx_head_ptr_wr_req_ptr(app_rx_head_ptr_wr_req_ptr),
      .rx_head_ptr_app_wr_req_rdy(rx_head_ptr_app_wr_req_rdy),
      .app_rx_head_ptr_rd_req_val(app_rx_head_ptr_rd_req_val),
      .app_rx_head_ptr_rd_req_flowid(app_rx_head_ptr_rd_req_flowid),
      .rx_head_ptr_app_rd_req_rdy(rx_head_ptr_app_rd_req_rdy),
      .rx_head_ptr_app_rd_resp_val(rx_head_ptr_app_rd_resp_val),
      .rx_head_ptr_app_rd_resp_ptr(rx_head_ptr_app_rd_resp_ptr),
      .app_rx_head_ptr_rd_resp_rdy(app_rx_head_ptr_rd_resp_rdy),
      .app_rx_commit_ptr_rd_req_val(app_rx_commit_ptr_rd_req_val),
      .app_rx_commit_ptr_rd_req_flowid(app_rx_commit_ptr_rd_req_flowid),
      .rx_commit_ptr_app_rd_req_rdy(rx_commit_ptr_app_rd_req_rdy),
      .rx_commit_ptr_app_rd_resp_val(rx_commit_ptr_app_rd_resp_val),
      .rx_commit_ptr_app_rd_resp_ptr(rx_commit_ptr_app_rd_resp_ptr),
      .app_rx_commit_ptr_rd_resp_rdy(app_rx_commit_ptr_rd_resp_rdy)
   );

   // Inputs change and outputs are sampled just after the falling edge.
   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      init_req_val = 0; init_req_flowid = '0; init_req_ptr = '0;
      eng_commit_wr_req_val = 0; eng_commit_wr_req_flowid = '0; eng_commit_wr_req_ptr = '0;
      app_rx_head_ptr_wr_req_val = 0; app_rx_head_ptr_wr_req_flowid = '0;
      app_rx_head_ptr_wr_req_ptr = '0;
      app_rx_head_ptr_rd_req_val = 0; app_rx_head_ptr_rd_req_flowid = '0;
      app_rx_commit_ptr_rd_req_val = 0; app_rx_commit_ptr_rd_req_flowid = '0;
      app_rx_head_ptr_rd_resp_rdy = 1; app_rx_commit_ptr_rd_resp_rdy = 1;
   endtask

   // Issues a read of both tables for one flow and checks the next-cycle responses.
   task automatic read_both(input logic [FLOWID_W-1:0] fid, input logic [PTR_W-1:0] exp_h,
                            input logic [PTR_W-1:0] exp_c, input string tag);
      app_rx_head_ptr_rd_req_val = 1; app_rx_head_ptr_rd_req_flowid = fid;
      app_rx_commit_ptr_rd_req_val = 1; app_rx_commit_ptr_rd_req_flowid = fid;
      step();
      app_rx_head_ptr_rd_req_val = 0; app_rx_commit_ptr_rd_req_val = 0;
      vec++;
      if ({rx_head_ptr_app_rd_resp_val, rx_head_ptr_app_rd_resp_ptr} !== {1'b1, exp_h}) begin
         err++;
         $display("FAIL %s head: got val=%b ptr=%h, expected val=1 ptr=%h", tag,
                  rx_head_ptr_app_rd_resp_val, rx_head_ptr_app_rd_resp_ptr, exp_h);
      end
      vec++;
      if ({rx_commit_ptr_app_rd_resp_val, rx_commit_ptr_app_rd_resp_ptr} !== {1'b1, exp_c}) begin
         err++;
         $display("FAIL %s commit: got val=%b ptr=%h, expected val=1 ptr=%h", tag,
                  rx_commit_ptr_app_rd_resp_val, rx_commit_ptr_app_rd_resp_ptr, exp_c);
      end
      step();
   endtask

   task automatic clear_window(input string tag);
      int zero_cycles = 0;
      for (int i = 0; i < 64; i++) begin
         if (rdy_all == 5'b0 && !rx_head_ptr_app_rd_resp_val && !rx_commit_ptr_app_rd_resp_val)
            zero_cycles++;
         step();
      end
      vec++;
      if (zero_cycles != 64) begin
         err++;
         $display("FAIL %s clear_cycles: got %0d quiet cycles, expected 64", tag, zero_cycles);
      end
      vec++;
      if (rdy_all !== 5'b11111) begin
         err++;
         $display("FAIL %s rdy_after_clear: got %b, expected 11111", tag, rdy_all);
      end
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1;
      repeat (3) step();
      vec++;
      if ({rdy_all, rx_head_ptr_app_rd_resp_val, rx_commit_ptr_app_rd_resp_val,
           rx_head_ptr_app_rd_resp_ptr, rx_commit_ptr_app_rd_resp_ptr} !== '0) begin
         err++;
         $display("FAIL reset_state: got rdy=%b hv=%b cv=%b hp=%h cp=%h, expected all 0",
                  rdy_all, rx_head_ptr_app_rd_resp_val, rx_commit_ptr_app_rd_resp_val,
                  rx_head_ptr_app_rd_resp_ptr, rx_commit_ptr_app_rd_resp_ptr);
      end
      rst = 0;
      clear_window("reset");
      read_both(6'd5, 32'h0, 32'h0, "flow5_after_clear");
      vec++;
      if (rx_head_ptr_app_rd_resp_val !== 1'b0 || rx_commit_ptr_app_rd_resp_val !== 1'b0) begin
         err++;
         $display("FAIL resp_consumed: got hv=%b cv=%b, expected 0 0",
                  rx_head_ptr_app_rd_resp_val, rx_commit_ptr_app_rd_resp_val);
      end
   endtask

   task automatic test_init_write();
      init_req_val = 1; init_req_flowid = 6'd3; init_req_ptr = 32'h1000;
      #1;
      vec++;
      if (init_req_rdy !== 1'b1) begin
         err++; $display("FAIL init_rdy: got %b, expected 1", init_req_rdy);
      end
      step();
      init_req_val = 0;
      eng_commit_wr_req_val = 1; eng_commit_wr_req_flowid = 6'd3; eng_commit_wr_req_ptr = 32'h1400;
      step();
      eng_commit_wr_req_val = 0;
      app_rx_head_ptr_wr_req_val = 1; app_rx_head_ptr_wr_req_flowid = 6'd3;
      app_rx_head_ptr_wr_req_ptr = 32'h1200;
      step();
      app_rx_head_ptr_wr_req_val = 0;
      read_both(6'd3, 32'h1200, 32'h1400, "flow3_writes");
   endtask

   task automatic test_init_priority();
      init_req_val = 1; init_req_flowid = 6'd7; init_req_ptr = 32'h10;
      eng_commit_wr_req_val = 1; eng_commit_wr_req_flowid = 6'd7; eng_commit_wr_req_ptr = 32'h99;
      app_rx_head_ptr_wr_req_val = 1; app_rx_head_ptr_wr_req_flowid = 6'd7;
      app_rx_head_ptr_wr_req_ptr = 32'h77;
      #1;
      vec++;
      if (rdy_all[4:2] !== 3'b100) begin
         err++; $display("FAIL init_blocks_writers: got %b, expected 100", rdy_all[4:2]);
      end
      step();
      init_req_val = 0; app_rx_head_ptr_wr_req_val = 0;
      #1;
      vec++;
      if (commit_eng_wr_req_rdy !== 1'b1) begin
         err++; $display("FAIL eng_rdy_after_init: got %b, expected 1", commit_eng_wr_req_rdy);
      end
      step();
      eng_commit_wr_req_val = 0;
      read_both(6'd7, 32'h10, 32'h99, "flow7_init_vs_eng");
   endtask

   task automatic test_bypass();
      init_req_val = 1; init_req_flowid = 6'd2; init_req_ptr = 32'h55;
      step();
      init_req_val = 0;
      app_rx_commit_ptr_rd_req_val = 1; app_rx_commit_ptr_rd_req_flowid = 6'd2;
      eng_commit_wr_req_val = 1; eng_commit_wr_req_flowid = 6'd2; eng_commit_wr_req_ptr = 32'hABCD;
      step();
      app_rx_commit_ptr_rd_req_val = 0; eng_commit_wr_req_val = 0;
      vec++;
      if (rx_commit_ptr_app_rd_resp_ptr !== 32'hABCD || rx_commit_ptr_app_rd_resp_val !== 1'b1) begin
         err++; $display("FAIL bypass_same_flow: got %h, expected 0000abcd",
                         rx_commit_ptr_app_rd_resp_ptr);
      end
      step();
      app_rx_commit_ptr_rd_req_val = 1; app_rx_commit_ptr_rd_req_flowid = 6'd2;
      eng_commit_wr_req_val = 1; eng_commit_wr_req_flowid = 6'd9; eng_commit_wr_req_ptr = 32'h1234;
      app_rx_head_ptr_rd_req_val = 1; app_rx_head_ptr_rd_req_flowid = 6'd3;
      app_rx_head_ptr_wr_req_val = 1; app_rx_head_ptr_wr_req_flowid = 6'd3;
      app_rx_head_ptr_wr_req_ptr = 32'h1300;
      step();
      app_rx_commit_ptr_rd_req_val = 0; eng_commit_wr_req_val = 0;
      app_rx_head_ptr_rd_req_val = 0; app_rx_head_ptr_wr_req_val = 0;
      vec++;
      if (rx_commit_ptr_app_rd_resp_ptr !== 32'hABCD) begin
         err++; $display("FAIL bypass_other_flow: got %h, expected 0000abcd",
                         rx_commit_ptr_app_rd_resp_ptr);
      end
      vec++;
      if (rx_head_ptr_app_rd_resp_ptr !== 32'h1300) begin
         err++; $display("FAIL head_bypass: got %h, expected 00001300",
                         rx_head_ptr_app_rd_resp_ptr);
      end
      step();
      read_both(6'd9, 32'h0, 32'h1234, "flow9");
      read_both(6'd2, 32'h55, 32'hABCD, "flow2_tables_isolated");
      read_both(6'd3, 32'h1300, 32'h1400, "flow3_tables_isolated");
   endtask

   task automatic test_backpressure();
      logic [FLOWID_W-1:0] fids [4] = '{6'd3, 6'd7, 6'd2, 6'd5};
      logic [PTR_W-1:0]    exps [4] = '{32'h1300, 32'h10, 32'h55, 32'h0};
      int stable = 0;
      app_rx_head_ptr_rd_resp_rdy = 0;
      app_rx_head_ptr_rd_req_val = 1; app_rx_head_ptr_rd_req_flowid = 6'd3;
      step();
      app_rx_head_ptr_rd_req_flowid = 6'd7;
      for (int i = 0; i < 5; i++) begin
         if (rx_head_ptr_app_rd_resp_val === 1'b1 && rx_head_ptr_app_rd_resp_ptr === 32'h1300 &&
             rx_head_ptr_app_rd_req_rdy === 1'b0)
            stable++;
         step();
      end
      vec++;
      if (stable != 5) begin
         err++; $display("FAIL stall_hold: got %0d stable cycles, expected 5", stable);
      end
      app_rx_head_ptr_rd_req_val = 0;
      app_rx_head_ptr_rd_resp_rdy = 1;
      #1;
      vec++;
      if (rx_head_ptr_app_rd_req_rdy !== 1'b1 || rx_head_ptr_app_rd_resp_ptr !== 32'h1300) begin
         err++; $display("FAIL stall_release: got rdy=%b ptr=%h, expected rdy=1 ptr=00001300",
                         rx_head_ptr_app_rd_req_rdy, rx_head_ptr_app_rd_resp_ptr);
      end
      step();
      vec++;
      if (rx_head_ptr_app_rd_resp_val !== 1'b0) begin
         err++; $display("FAIL stall_drain: got val=%b, expected 0", rx_head_ptr_app_rd_resp_val);
      end
      app_rx_head_ptr_rd_req_val = 1; app_rx_head_ptr_rd_req_flowid = fids[0];
      for (int k = 0; k < 4; k++) begin
         step();
         if (k < 3) app_rx_head_ptr_rd_req_flowid = fids[k+1];
         else app_rx_head_ptr_rd_req_val = 0;
         vec++;
         if (rx_head_ptr_app_rd_resp_val !== 1'b1 || rx_head_ptr_app_rd_resp_ptr !== exps[k]) begin
            err++; $display("FAIL pipelined_read%0d: got val=%b ptr=%h, expected val=1 ptr=%h",
                            k, rx_head_ptr_app_rd_resp_val, rx_head_ptr_app_rd_resp_ptr, exps[k]);
         end
      end
      step();
   endtask

   task automatic test_reset_midstream();
      app_rx_head_ptr_rd_resp_rdy = 0;
      app_rx_head_ptr_rd_req_val = 1; app_rx_head_ptr_rd_req_flowid = 6'd3;
      step();
      app_rx_head_ptr_rd_req_val = 0;
      vec++;
      if (rx_head_ptr_app_rd_resp_val !== 1'b1) begin
         err++; $display("FAIL pending_before_rst: got %b, expected 1", rx_head_ptr_app_rd_resp_val);
      end
      rst = 1;
      step();
      rst = 0;
      vec++;
      if (rx_head_ptr_app_rd_resp_val !== 1'b0 || rx_head_ptr_app_rd_resp_ptr !== 32'h0) begin
         err++; $display("FAIL rst_drops_resp: got val=%b ptr=%h, expected val=0 ptr=00000000",
                         rx_head_ptr_app_rd_resp_val, rx_head_ptr_app_rd_resp_ptr);
      end
      app_rx_head_ptr_rd_resp_rdy = 1;
      clear_window("midreset");
      read_both(6'd3, 32'h0, 32'h0, "flow3_after_reclear");
   endtask

   initial begin
      test_reset();
      test_init_write();
      test_init_priority();
      test_bypass();
      test_backpressure();
      test_reset_midstream();
      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end

endmodule

// File: doc/tcp_rx_ptr_store.md
Name: tcp_rx_ptr_store

Overview:
- Per-flow RX pointer store for the TCP RX path.
- Holds a head pointer (app-consumed) and a commit pointer (engine-written, in-order data end) for each flow.
- Serves the app-side pointer-interface controller: head-pointer writes, head-pointer reads and commit-pointer reads, all valid/ready handshakes.
- Also takes commit-pointer updates from the TCP RX engine and flow-init writes from the flow setup path.

Parameters:
- FLOWID_W, 6, flow ID width; table depth = 2^FLOWID_W.
- PTR_W, 32, pointer width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- init_req_val  in  1  flow-init request
- init_req_flowid  in  FLOWID_W  flow being initialised
- init_req_ptr  in  PTR_W  initial value for both head and commit
- init_req_rdy  out  1  init accepted
- eng_commit_wr_req_val  in  1  engine commit-pointer write
- eng_commit_wr_req_flowid  in  FLOWID_W  target flow
- eng_commit_wr_req_ptr  in  PTR_W  new commit pointer
- commit_eng_wr_req_rdy  out  1  engine write accepted
- app_rx_head_ptr_wr_req_val  in  1  app head-pointer write
- app_rx_head_ptr_wr_req_flowid  in  FLOWID_W  target flow
- app_rx_head_ptr_wr_req_ptr  in  PTR_W  new head pointer
- rx_head_ptr_app_wr_req_rdy  out  1  head write accepted
- app_rx_head_ptr_rd_req_val  in  1  head read request
- app_rx_head_ptr_rd_req_flowid  in  FLOWID_W  flow to read
- rx_head_ptr_app_rd_req_rdy  out  1  head read accepted
- rx_head_ptr_app_rd_resp_val  out  1  head read data valid
- rx_head_ptr_app_rd_resp_ptr  out  PTR_W  head read data
- app_rx_head_ptr_rd_resp_rdy  in  1  head response consumed
- app_rx_commit_ptr_rd_req_val  in  1  commit read request
- app_rx_commit_ptr_rd_req_flowid  in  FLOWID_W  flow to read
- rx_commit_ptr_app_rd_req_rdy  out  1  commit read accepted
- rx_commit_ptr_app_rd_resp_val  out  1  commit read data valid
- rx_commit_ptr_app_rd_resp_ptr  out  PTR_W  commit read data
- app_rx_commit_ptr_rd_resp_rdy  in  1  commit response consumed

Behaviour:
- Storage and FSM
  - Two tables (HEAD, COMMIT), each 1 write port + 1 synchronous read port, 1-cycle read latency.
  - FSM states CLEAR, RUN. Reset -> CLEAR with clr_idx=0.
  - CLEAR: write 0 to entry clr_idx in both tables each cycle, clr_idx++; at clr_idx = 2^FLOWID_W-1 write it, then -> RUN (clear takes 2^FLOWID_W cycles).
  - In CLEAR, all req_rdy outputs are 0 and both resp_val are 0.
- Reset values: every rdy output 0, both resp_val 0, resp_ptr 0.
- rst asserted mid-operation: pending responses are dropped and the clear restarts from 0.
- Write arbitration in RUN
  - init_req_rdy = 1.
  - HEAD table: init wins; rx_head_ptr_app_wr_req_rdy = !init_req_val.
  - COMMIT table: init wins; commit_eng_wr_req_rdy = !init_req_val.
  - A write takes effect at the clock edge where val&rdy.
- Reads
  - Each table has a 1-entry response register; the two tables are fully independent.
  - rd_req_rdy = RUN & (!resp_val | resp_rdy).
  - Read accepted in cycle N -> resp_val=1 with data in cycle N+1.
  - resp_val and resp_ptr hold until resp_val&resp_rdy; resp_val clears then unless a new read was accepted the same cycle.
  - Back-to-back reads at full rate while resp_rdy=1.
- Read/write collision: a read accepted in the same cycle as an accepted write to the same flow returns the NEW value (write-first bypass). A different flow is unaffected.
- Pointers are stored verbatim; no arithmetic. Wrap-around is the consumer's concern.
- A head write never alters COMMIT, and an engine write never alters HEAD.

Test Plan:
- Reset, then sample for 64 cycles -> all rdy 0 for exactly 64 cycles. Cycle 65: all rdy 1. Read of flow 5 head and commit -> 0, 0.
- init flow 3 ptr 0x1000; eng commit flow 3 = 0x1400; app head write flow 3 = 0x1200; then read both together -> head 0x1200, commit 0x1400, both resp_val one cycle after accept.
- init_req_val and eng write on the same cycle, both flow 7 (init ptr 0x10, eng 0x99) -> commit_eng_wr_req_rdy=0 that cycle. Engine holds val and writes next cycle. Final commit read 0x99, head 0x10.
- Commit read of flow 2 issued in the same cycle as eng write flow 2 = 0xABCD -> response 0xABCD. Same-cycle write to flow 9 instead -> old flow-2 value.
- Hold app_rx_head_ptr_rd_resp_rdy=0 for 5 cycles after a head read -> resp_val/ptr stable, rd_req_rdy=0. Release -> handshake, then 4 pipelined reads complete in 4 consecutive cycles.
- Assert rst while a head response is pending -> resp_val drops next cycle and a full 64-cycle clear reruns. Afterwards, flow-3 head reads 0.
